// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the value UART transmitter
// Contents: tx_state_t (FSM states), UART_DATA_BITS, UART_DEFAULT_CLKS_PER_BIT.
// The PARITY state exists in the enum in every build; it is only reachable when
// VALUE_UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - bit-period counter producing one tick per serial bit
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   clear - restart the bit period (counter to 0 on the next edge)
//   tick  - high on the last cycle of each bit period
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] baud_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
        end else if (clear || (baud_cnt == CNT_LAST)) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
        end
    end

    assign tick = (baud_cnt == CNT_LAST);

endmodule

// File: rtl/value_uart_tx.sv
// rtl/value_uart_tx.sv - sends value as a UART frame whenever it differs from the last value sent
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset (aborts any frame, tx high at once)
//   value - 8-bit count to report, synchronous to clk
//   tx    - UART line, idle high, registered
//   busy  - high while a frame is in flight, registered
// Parameter CLKS_PER_BIT (>= 2): clock cycles per serial bit.
// Optional feature macro VALUE_UART_TX_PARITY_EN: adds an even parity bit (8E1).
module value_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    output logic       tx,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_t  state, state_nxt;
    logic [7:0] last_sent, last_sent_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       tx_nxt, busy_nxt;
    logic       clear;
    logic       tick;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_sent <= 8'h00;
            shreg     <= 8'h00;
            bit_cnt   <= 3'd0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_sent <= last_sent_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            tx        <= tx_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        last_sent_nxt = last_sent;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        tx_nxt        = tx;
        busy_nxt      = busy;
        clear         = 1'b0;

        case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                // value is only looked at here, so changes made mid-frame
                // collapse into whichever value is present on return to IDLE.
                if (value != last_sent) begin
                    shreg_nxt     = value;
                    last_sent_nxt = value;
                    tx_nxt        = 1'b0;
                    busy_nxt      = 1'b1;
                    clear         = 1'b1;
                    state_nxt     = START;
                end
            end

            START: begin
                if (tick) begin
                    tx_nxt      = shreg[0];
                    bit_cnt_nxt = 3'd0;
                    state_nxt   = DATA;
                end
            end

            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef VALUE_UART_TX_PARITY_EN
                        // shreg has been shifted away; last_sent still holds the byte.
                        tx_nxt    = ^last_sent;
                        state_nxt = PARITY;
`else
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
`endif
                    end else begin
                        shreg_nxt   = shreg >> 1;
                        tx_nxt      = shreg[1];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end

`ifdef VALUE_UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tx_nxt    = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif

            STOP: begin
                if (tick) begin
                    tx_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_value_uart_tx.sv
// tb/tb_value_uart_tx.sv - self-checking bench for value_uart_tx with a waveform-queue reference model
`timescale 1ns/1ps
module tb_value_uart_tx;

    localparam int N = 4;
`ifdef VALUE_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * N;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [7:0] value = 8'h00;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    value_uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .value(value),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level of bit position b of the frame carrying v.
    function automatic logic frame_bit(input logic [7:0] v, input int b);
        if (b == 0)                   return 1'b0;
        else if (b <= 8)              return v[b-1];
        else if (b == FRAME_BITS - 1) return 1'b1;
        else                          return ^v;
    endfunction

    // Reference model: a queue of expected {tx,busy} per cycle.
    logic [1:0] exp_q[$];
    logic [7:0] m_last = 8'h00;
    logic       m_tx   = 1'b1;
    logic       m_busy = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_last = 8'h00;
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end else begin
            if (!m_busy && value != m_last) begin
                m_last = value;
                for (int b = 0; b < FRAME_BITS; b++)
                    for (int c = 0; c < N; c++)
                        exp_q.push_back({frame_bit(value, b), 1'b1});
            end
            if (exp_q.size() > 0) {m_tx, m_busy} = exp_q.pop_front();
            else begin
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("tx_cycle", tx, m_tx);
        check("busy_cycle", busy, m_busy);
    end

    // busy run lengths of completed (non-aborted) frames
    int len_q[$];
    int run = 0;
    always @(negedge clk) begin
        if (rst) run = 0;
        else if (busy) run++;
        else if (run != 0) begin
            len_q.push_back(run);
            run = 0;
        end
    end

    // Simple receiver decoding frames off tx.
    logic [7:0] rx_q[$];
    logic       rxp_q[$];
    logic       rx_abort  = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] rx_d;
    logic       rx_p;

    always @(posedge rst) rx_abort = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && busy && !prev_busy) begin
                rx_abort = 1'b0;
                rx_d = 8'h00;
                rx_p = 1'b0;
                for (int i = 0; i < 8 && !rx_abort; i++) begin
                    repeat (N) @(negedge clk);
                    rx_d[i] = tx;
                end
                if (FRAME_BITS == 11 && !rx_abort) begin
                    repeat (N) @(negedge clk);
                    rx_p = tx;
                end
                if (!rx_abort) begin
                    repeat (N) @(negedge clk);
                    check("stop_bit", tx, 1'b1);
                    rx_q.push_back(rx_d);
                    rxp_q.push_back(rx_p);
                end
                prev_busy = 1'b1;
            end else begin
                prev_busy = busy;
            end
        end
    end

    logic [9:0] pat41 = 10'b1010000010;   // start, 0x41 LSB first, stop
    int         n_rx;

    initial begin
        // reset, idle with value 0: nothing may be sent
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(posedge clk);
        check("idle_no_rx", rx_q.size(), 0);
        check("idle_no_busy_run", len_q.size(), 0);

        // 0x41, with 0x42 then 0x43 presented mid-frame
        #1 value = 8'h41;
        @(posedge clk);
        #1;
        check("start_low", tx, 1'b0);
        check("busy_rise", busy, 1'b1);
        fork
            begin
                @(posedge clk);
                #1;
                for (int b = 0; b < 9; b++) begin
                    check("bit41", tx, pat41[b]);
                    repeat (N) @(posedge clk);
                    #1;
                end
            end
            begin
                repeat (8) @(posedge clk);
                #2 value = 8'h42;
                repeat (8) @(posedge clk);
                #2 value = 8'h43;
            end
        join
        repeat (2 * FRAME_CYC) @(posedge clk);
        check("drop_rx_count", rx_q.size(), 2);
        check("drop_rx0", rx_q[0], 8'h41);
        check("drop_rx1", rx_q[1], 8'h43);
        check("drop_idle", busy, 1'b0);

        // 0x05, wander to 0x07 and back: one frame only
        #1 value = 8'h05;
        repeat (10) @(posedge clk);
        #1 value = 8'h07;
        repeat (10) @(posedge clk);
        #1 value = 8'h05;
        repeat (FRAME_CYC + 60) @(posedge clk);
        check("revert_rx_count", rx_q.size(), 3);
        check("revert_rx2", rx_q[2], 8'h05);
        check("revert_idle", busy, 1'b0);

        // randomized value changes at random spacing
        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(1, 60)) @(posedge clk);
            #1 value = 8'($urandom);
        end
        repeat (2 * FRAME_CYC + 10) @(posedge clk);
        check("rand_final_byte", rx_q[rx_q.size() - 1], value);
        check("rand_idle", busy, 1'b0);

        // reset during the 4th data bit
        #1 value = ~value;
        @(posedge clk);
        repeat (17) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_tx_high", tx, 1'b1);
        check("rst_busy_low", busy, 1'b0);
        value = 8'h05;
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        n_rx = rx_q.size();
        repeat (FRAME_CYC + 10) @(posedge clk);
        check("post_rst_rx_count", rx_q.size(), n_rx + 1);
        check("post_rst_rx", rx_q[rx_q.size() - 1], 8'h05);

`ifdef VALUE_UART_TX_PARITY_EN
        #1 value = 8'h03;
        repeat (FRAME_CYC + 10) @(posedge clk);
        #1 value = 8'h07;
        repeat (FRAME_CYC + 10) @(posedge clk);
        check("parity_03", rxp_q[rxp_q.size() - 2], 1'b0);
        check("parity_07", rxp_q[rxp_q.size() - 1], 1'b1);
`endif

        check("frame_count", (len_q.size() > 0) ? 1 : 0, 1);
        foreach (len_q[i]) check("frame_len", len_q[i], FRAME_CYC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/value_uart_tx.md
# value_uart_tx

Serial transmitter for the button-press count. It watches the 8-bit `value` bus and sends a standard 8N1 UART frame whenever `value` differs from the last value sent. The frame goes out on `tx` to the host. It sits beside the button counter at the UART end of the design, which is the outbound path for the count.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200 baud). Legal range is ≥ 2.
- `clk`  input  1: system clock; all state updates on the rising edge.
- `rst`  input  1: reset, asynchronous, active-high.
- `value`  input  8: count to report; synchronous to `clk`.
- `tx`  output  1: UART line, idle high.
- `busy`  output  1: high while a frame is in flight.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Internal registers:
  - `last_sent[7:0]`: value of the most recent frame.
  - `shreg[7:0]`: frame shift register.
  - `bit_cnt[2:0]`: data-bit index.
  - `baud_cnt`: width `$clog2(CLKS_PER_BIT)`, counts 0..CLKS_PER_BIT-1.
- IDLE:
  - `tx`=1, `busy`=0.
  - On an edge where `value != last_sent`:
    - `shreg<=value`, `last_sent<=value`;
    - `tx<=0`, `busy<=1`, `baud_cnt<=0`;
    - next state START.
- Bit timing: every state after IDLE holds `tx` for exactly CLKS_PER_BIT cycles. The state advances on the edge where `baud_cnt==CLKS_PER_BIT-1`, and `baud_cnt` returns to 0 on that same edge.
- START → DATA:
  - `tx<=shreg[0]`, `bit_cnt<=0`.
- DATA:
  - On each bit boundary, shift `shreg` right and drive `tx` from the new `shreg[0]`. Bits go out LSB first.
  - After bit 7 completes, go to STOP (or PARITY), `tx<=1`.
- STOP:
  - `tx`=1 for one bit time.
  - Then IDLE with `busy<=0`.
- `value` is ignored while not in IDLE.
  - On return to IDLE it is compared again, so only the latest value is sent. Intermediate values are dropped by design.
- If `value` returns to `last_sent` before IDLE, no further frame is sent.
- Reset:
  - Values: `tx`=1, `busy`=0, state IDLE, `last_sent`=0, all counters 0.
  - The value 0 after reset is not transmitted.
  - Reset mid-frame aborts the frame at once. `tx` goes high asynchronously, with no glitch low.

## Timing
- Latency:
  - A new `value` registered on edge N is detected on edge N+1 (compared combinationally in IDLE).
  - The start bit is visible after edge N+1.
- Frame length from start-bit falling edge to IDLE is 10·CLKS_PER_BIT cycles (11·CLKS_PER_BIT with parity).
- `busy` rises on the same edge `tx` falls and falls on the edge the stop bit ends.
- IDLE lasts at least 1 cycle between frames, so back-to-back frames are separated by one extra high cycle.
- `tx` and `busy` are registered outputs, with no combinational path from `value`.

## Configuration
- Macro: `VALUE_UART_TX_PARITY_EN`.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - `tx` = even parity (XOR of the 8 data bits, taken from `last_sent`) for one bit time.
  - Frame is 11 bits (8E1).
- Undefined:
  - PARITY state and its logic are absent.
  - Frame is 8N1, 10 bits.

## Structure
- Package `uart_pkg`:
  - state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constant `UART_DATA_BITS = 8`;
  - localparam for the default CLKS_PER_BIT.
- One sub-module, `baud_tick_gen`:
  - parameter CLKS_PER_BIT;
  - inputs `clk`, `rst`, `clear`;
  - outputs the `tick` pulse on the last cycle of each bit.
  - The FSM asserts `clear` when it leaves IDLE.

## Test plan
- Reset with `value`=0, CLKS_PER_BIT=4, run 100 cycles → `tx`=1 and `busy`=0 throughout; no frame.
- `value`=0x41 → `tx` goes low one cycle later.
  - Each bit is held 4 cycles: 0, 1,0,0,0,0,0,1,0, 1.
  - `busy` is high for 40 cycles.
- During the 0x41 frame, `value`→0x42 then →0x43 → after 0x41 completes and 1 idle cycle, exactly one frame 0x43 is sent; 0x42 is never sent.
- During the 0x05 frame, `value`→0x07 then back to 0x05 → a single frame only; `busy` stays low afterward.
- Assert `rst` in the 4th data bit → `tx`=1 and `busy`=0 immediately.
  - After release with `value`=0x05 (≠0), a full 0x05 frame is sent.
- With `VALUE_UART_TX_PARITY_EN`, `value`=0x03 → parity bit 0; `value`=0x07 → parity bit 1; frame is 44 cycles at CLKS_PER_BIT=4.
